uart_tx_feeder: RTL and testbench

Upstream stage of the UART transmit path. Buffers parallel bytes from the system side in a small synchronous FIFO and launches them one at a time into the UART TX controller. It drives a single-cycle data_valid strobe with a stable data word, then tracks the TX busy flag until the frame completes. Same clock domain as the UART TX controller.

---
 rtl/uart_tx_feeder.sv | 134 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART TX controller: launches one queued word per
// frame with a single-cycle strobe and watches tx_busy_i to pace the next launch.
module uart_tx_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  input  logic                  tx_busy_i,
  output logic                  tx_data_valid_o,
  output logic [DATA_WIDTH-1:0] tx_p_data_o,
  output logic                  timeout_err_o
);

  localparam int TW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q, overflow_q;
  state_e                state_q;
  logic [TW-1:0]         tmo_cnt_q;
  logic                  tx_valid_q, timeout_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  wr_accept_s, launch_s;

  // Accept/pop decisions and next pointer/occupancy values; a pop never frees
  // room for a write that arrives while full.
  always_comb begin
    wr_accept_s = wr_en_i && !full_q;
    launch_s    = (state_q == ST_IDLE) && !empty_q && !tx_busy_i;
    wr_ptr_d    = wr_accept_s ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = launch_s    ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    case ({wr_accept_s, launch_s})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == (ADDR_WIDTH+1)'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= wr_en_i && full_q;
    end
  end

  // Storage array; contents survive reset but are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Dispatch FSM: launch strobe, wait for busy to rise (with timeout), then fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tmo_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (launch_s) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_valid_q <= 1'b1;
            tmo_cnt_q  <= '0;
            state_q    <= ST_WAIT_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= ST_WAIT_DONE;
          end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign full_o          = full_q;
  assign empty_o         = empty_q;
  assign count_o         = count_q;
  assign overflow_o      = overflow_q;
  assign tx_data_valid_o = tx_valid_q;
  assign tx_p_data_o     = tx_data_q;
  assign timeout_err_o   = timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small TX-controller busy model.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_data_valid, timeout_err;
  logic [3:0] count;
  logic [7:0] tx_p_data;
  logic       tx_busy;
  logic       force_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       model_on = 1'b0;
  int         mcnt = 0;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         novf = 0;
  logic [7:0] lq[$];
  int         sq[$];
  int         tq[$];

  assign tx_busy = force_busy | model_busy;

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow),
    .tx_busy_i(tx_busy), .tx_data_valid_o(tx_data_valid),
    .tx_p_data_o(tx_p_data), .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  // TX controller model: busy rises 2 cycles after the strobe, held 10 cycles.
  always begin
    @(posedge clk);
    #3;
    if (!rst) begin
      mcnt = 0;
      model_busy = 1'b0;
    end else if (model_on && tx_data_valid) begin
      mcnt = 1;
    end else if (mcnt != 0) begin
      mcnt++;
      model_busy = (mcnt >= 3 && mcnt <= 12);
      if (mcnt >= 13) mcnt = 0;
    end
  end

  // Event recorder: launched words, strobe and timeout cycles, overflow cycles.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (tx_data_valid) begin
      lq.push_back(tx_p_data);
      sq.push_back(cyc);
    end
    if (overflow) novf++;
    if (timeout_err) tq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int ls, ts, ov;

  initial begin
    // Reset state
    tick(2);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_pdata", tx_p_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout_err, 0);
    rst = 1'b1;
    tick(20);
    chk("idle_nostrobe", lq.size(), 0);
    chk("idle_empty", empty, 1);

    // Single write, 2-cycle launch latency
    model_on = 1'b1;
    ls = lq.size();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("w1_count", count, 1);
    chk("w1_empty", empty, 0);
    chk("w1_valid_early", tx_data_valid, 0);
    tick();
    chk("w1_valid", tx_data_valid, 1);
    chk("w1_pdata", tx_p_data, 8'hA5);
    chk("w1_count0", count, 0);
    tick();
    chk("w1_valid_1cyc", tx_data_valid, 0);
    tick(30);
    chk("w1_nstrobe", lq.size() - ls, 1);
    chk("w1_word", lq[ls], 8'hA5);
    chk("w1_no_tmo", tq.size(), 0);
    chk("w1_pdata_hold", tx_p_data, 8'hA5);
    chk("w1_busy_done", tx_busy, 0);

    // Burst of 10 with TX stalled
    force_busy = 1'b1;
    ls = lq.size();
    ov = novf;
    for (int i = 1; i <= 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      chk("burst_count", count, (i < 8) ? i : 8);
      chk("burst_full", full, (i >= 8) ? 1 : 0);
    end
    wr_en = 1'b0;
    tick();
    chk("burst_ovf_pulses", novf - ov, 2);
    chk("burst_ovf_low", overflow, 0);
    chk("burst_count8", count, 8);
    chk("burst_no_launch", lq.size() - ls, 0);
    force_busy = 1'b0;
    tick(140);
    chk("burst_nlaunch", lq.size() - ls, 8);
    for (int k = 0; k < 8; k++) chk("burst_order", lq[ls + k], 8'(k + 1));
    chk("burst_drained", empty, 1);

    // Simultaneous write and launch at count 3
    force_busy = 1'b1;
    ls = lq.size();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("sim_count3", count, 3);
    force_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h14;
    tick();
    wr_en = 1'b0;
    chk("sim_count_hold", count, 3);
    chk("sim_valid", tx_data_valid, 1);
    chk("sim_pdata", tx_p_data, 8'h11);
    tick(80);
    chk("sim_nlaunch", lq.size() - ls, 4);
    for (int k = 0; k < 4; k++) chk("sim_order", lq[ls + k], 8'(8'h11 + k));
    chk("sim_count0", count, 0);

    // Busy never rises
    model_on = 1'b0;
    ls = lq.size();
    ts = tq.size();
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_data = 8'h6B;
    tick();
    wr_en = 1'b0;
    tick(20);
    chk("tmo_nlaunch", lq.size() - ls, 2);
    chk("tmo_word0", lq[ls], 8'h5A);
    chk("tmo_word1", lq[ls + 1], 8'h6B);
    chk("tmo_npulse", tq.size() - ts, 2);
    chk("tmo_delay", tq[ts] - sq[ls], 4);
    chk("tmo_relaunch_gap", sq[ls + 1] - tq[ts], 1);
    tick(20);
    chk("tmo_no_relaunch", lq.size() - ls, 2);

    // Reset during WAIT_DONE with 4 queued
    model_on = 1'b1;
    wr_en = 1'b1; wr_data = 8'h31;
    tick();
    wr_en = 1'b0;
    tick(4);
    chk("rmid_busy", tx_busy, 1);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("rmid_count4", count, 4);
    rst = 1'b0;
    #1;
    chk("rmid_valid", tx_data_valid, 0);
    chk("rmid_pdata", tx_p_data, 0);
    chk("rmid_count", count, 0);
    chk("rmid_empty", empty, 1);
    chk("rmid_full", full, 0);
    chk("rmid_ovf", overflow, 0);
    chk("rmid_tmo", timeout_err, 0);
    tick(2);
    rst = 1'b1;
    ls = lq.size();
    tick(30);
    chk("rmid_no_strobe", lq.size() - ls, 0);
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    tick(30);
    chk("rmid_new_launch", lq.size() - ls, 1);
    chk("rmid_new_word", lq[ls], 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
